// File: rtl/traffic_light_pkg.sv
// Shared types and default phase durations for the traffic-light sequencer.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_t;

  localparam int DEF_RED_CYCLES    = 32;
  localparam int DEF_GREEN_CYCLES  = 20;
  localparam int DEF_YELLOW_CYCLES = 7;
  localparam int DEF_CNT_W         = 6;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Enable/lamp bundle for one signal head; master drives enable, slave drives the lamps.
interface traffic_light_ctrl_if;

  logic enable;
  logic red;
  logic yellow;
  logic green;

  modport master (output enable, input red, input yellow, input green);
  modport slave  (input enable, output red, output yellow, output green);

endinterface

// File: rtl/traffic_light_ctrl.sv
// RED -> GREEN -> YELLOW sequencer with per-phase enabled-cycle counts and registered one-hot lamps.
module traffic_light_ctrl
  import traffic_light_pkg::*;
#(
  parameter int RED_CYCLES    = DEF_RED_CYCLES,
  parameter int GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Enable,
  output logic Red,
  output logic Yellow,
  output logic Green
);

  localparam logic [1:0] ST_RED    = PH_RED;
  localparam logic [1:0] ST_GREEN  = PH_GREEN;
  localparam logic [1:0] ST_YELLOW = PH_YELLOW;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             red_q, yellow_q, green_q;

  logic [CNT_W-1:0] last_cnt;
  logic [1:0]       next_phase;
  logic             illegal;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_q <= ST_RED;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    last_cnt   = RED_LAST;
    next_phase = ST_GREEN;
    illegal    = 1'b0;
    case (phase_q)
      ST_RED:    begin last_cnt = RED_LAST;    next_phase = ST_GREEN;  end
      ST_GREEN:  begin last_cnt = GREEN_LAST;  next_phase = ST_YELLOW; end
      ST_YELLOW: begin last_cnt = YELLOW_LAST; next_phase = ST_RED;    end
      default:   illegal = 1'b1;
    endcase

    // The unused encoding recovers regardless of Enable so the lamps can never stick dark.
    if (illegal) begin
      phase_d = ST_RED;
      cnt_d   = '0;
    end else if (Enable) begin
      if (cnt_q >= last_cnt) begin
        phase_d = next_phase;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Decoding phase_d makes the lamp change visible right after the transition edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      red_q    <= 1'b1;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
    end else begin
      red_q    <= (phase_d == ST_RED);
      yellow_q <= (phase_d == ST_YELLOW);
      green_q  <= (phase_d == ST_GREEN);
    end
  end

  assign Red    = red_q;
  assign Yellow = yellow_q;
  assign Green  = green_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench: run-length vector table for the default sequencer plus enable/reset/LEN=1 sequences.
module tb_traffic_light_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  traffic_light_ctrl_if ia ();
  traffic_light_ctrl_if ib ();

  traffic_light_ctrl dut_a (
    .Clock  (clk),
    .Reset  (rst_a),
    .Enable (ia.enable),
    .Red    (ia.red),
    .Yellow (ia.yellow),
    .Green  (ia.green)
  );

  traffic_light_ctrl #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .CNT_W         (6)
  ) dut_b (
    .Clock  (clk),
    .Reset  (rst_b),
    .Enable (ib.enable),
    .Red    (ib.red),
    .Yellow (ib.yellow),
    .Green  (ib.green)
  );

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  typedef struct {
    logic       rst;
    logic       en;
    int         n;
    logic [2:0] lamps;
  } vec_t;

  int checks = 0;
  int passed = 0;
  bit oh_on  = 1'b0;

  function automatic logic [2:0] lamps_a();
    return {ia.red, ia.yellow, ia.green};
  endfunction

  function automatic logic [2:0] lamps_b();
    return {ib.red, ib.yellow, ib.green};
  endfunction

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got RYG=%b expected RYG=%b", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Exactly one lamp on, every cycle, both instances.
  always @(negedge clk) begin
    if (oh_on) begin
      checks++;
      if ($countones({ia.red, ia.yellow, ia.green}) == 1 &&
          $countones({ib.red, ib.yellow, ib.green}) == 1) passed++;
      else $display("FAIL onehot: got a=%b b=%b required exactly one lamp each",
                    {ia.red, ia.yellow, ia.green}, {ib.red, ib.yellow, ib.green});
    end
  end

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 1'b0,  3, L_R};  // reset held 3 cycles
    tbl[1]  = '{1'b0, 1'b0,  4, L_R};  // released, Enable low: hold
    tbl[2]  = '{1'b0, 1'b1, 31, L_R};  // edges 1..31
    tbl[3]  = '{1'b0, 1'b1, 20, L_G};  // edges 32..51
    tbl[4]  = '{1'b0, 1'b1,  7, L_Y};  // edges 52..58
    tbl[5]  = '{1'b0, 1'b1, 32, L_R};
    tbl[6]  = '{1'b0, 1'b1, 20, L_G};
    tbl[7]  = '{1'b0, 1'b1,  7, L_Y};
    tbl[8]  = '{1'b0, 1'b1, 32, L_R};
    tbl[9]  = '{1'b0, 1'b1, 20, L_G};
    tbl[10] = '{1'b0, 1'b1,  7, L_Y};
    tbl[11] = '{1'b0, 1'b1,  1, L_R};
    tbl[12] = '{1'b0, 1'b0,  5, L_R};  // freeze in RED cnt=0

    rst_a = 1'b1; ia.enable = 1'b0;
    rst_b = 1'b1; ib.enable = 1'b0;
    tick();
    oh_on = 1'b1;
    check("reset_first_edge", lamps_a(), L_R);

    for (int i = 0; i < 13; i++) begin
      rst_a = tbl[i].rst;
      ia.enable = tbl[i].en;
      for (int k = 0; k < tbl[i].n; k++) begin
        tick();
        check($sformatf("vec%0d.edge%0d", i, k), lamps_a(), tbl[i].lamps);
      end
      $display("vec %0d: rst=%b en=%b edges=%0d expect RYG=%b", i, tbl[i].rst, tbl[i].en,
               tbl[i].n, tbl[i].lamps);
    end

    // Enable dropped at GREEN cnt=5 for 10 cycles, then resumed.
    rst_a = 1'b1; ia.enable = 1'b0; tick();
    rst_a = 1'b0; ia.enable = 1'b1;
    for (int k = 0; k < 37; k++) tick();
    check("pause_at_green_cnt5", lamps_a(), L_G);
    ia.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("pause_hold%0d", k), lamps_a(), L_G);
    end
    ia.enable = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      check($sformatf("pause_resume%0d", k), lamps_a(), L_G);
    end
    tick();
    check("pause_green_to_yellow", lamps_a(), L_Y);
    $display("seq enable-pause: green held 10 disabled cycles, 20 enabled edges total");

    // One-edge reset in YELLOW cnt=3 (with Enable high, reset wins).
    rst_a = 1'b1; ia.enable = 1'b0; tick();
    rst_a = 1'b0; ia.enable = 1'b1;
    for (int k = 0; k < 55; k++) tick();
    check("mid_yellow_cnt3", lamps_a(), L_Y);
    rst_a = 1'b1;
    tick();
    check("reset_mid_yellow", lamps_a(), L_R);
    rst_a = 1'b0;
    for (int k = 0; k < 31; k++) begin
      tick();
      check($sformatf("post_reset_red%0d", k), lamps_a(), L_R);
    end
    tick();
    check("post_reset_green", lamps_a(), L_G);
    $display("seq mid-yellow reset: red for 31 edges, green on edge 32");

    // LEN=1 instance: rotates every enabled edge.
    rst_b = 1'b1; ib.enable = 1'b1; tick();
    check("len1_reset", lamps_b(), L_R);
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("len1_rot%0d", k), lamps_b(),
            (k % 3 == 0) ? L_G : (k % 3 == 1) ? L_Y : L_R);
    end
    tick();
    check("len1_rot6", lamps_b(), L_G);
    ib.enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("len1_hold%0d", k), lamps_b(), L_G);
    end
    ib.enable = 1'b1;
    tick();
    check("len1_resume", lamps_b(), L_Y);
    rst_b = 1'b1;
    tick();
    check("len1_reset_priority", lamps_b(), L_R);
    rst_b = 1'b0;
    $display("seq len1: R,G,Y rotation per enabled edge");

    oh_on = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
